recompute_controller_mp: RTL and testbench
==========================================

Name: recompute_controller_mp

Overview:
Multi-proxy successor to the single-proxy column recompute controller. Serves one systolic-array column: captures the STW fault map, assigns up to NUM_PROXIES spare (proxy) PEs to faulty rows in ascending row order, and loads each proxy with its row's weight. It then switches the proxies to matmul mode, routes the faulty rows' left inputs to them, and releases every assignment when new weights are loaded. Reports faults left without a proxy.

Parameters:
ROWS, 4, PE rows in the column
WORD_SIZE, 16, data width
NUM_PROXIES, 2, proxy PEs available to this column (1..ROWS)
COL_IDX, 0, column index (informational; no behavioural effect)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
set_stationary_mode  in  1  weight (re)load phase; releases all assignments
matmul_mode  in  1  matmul phase active
STW_complete  in  1  STW results valid this cycle
STW_result_mat  in  ROWS  per-row STW result, 1=pass, 0=faulty
rcm_idx_sel  out  $clog2(ROWS)  row index driving the external weight mux
rcm_in_weight  in  WORD_SIZE  weight of row rcm_idx_sel, same cycle
rcm_left_in  in  ROWS*WORD_SIZE  left inputs of all rows, row r at [r*WORD_SIZE +: WORD_SIZE]
proxy_left_in  out  NUM_PROXIES*WORD_SIZE  per-proxy left input, registered
rcm_weight  out  NUM_PROXIES*WORD_SIZE  per-proxy weight to load
load_proxy  out  NUM_PROXIES  one-cycle weight-load strobe per proxy
proxy_matmul  out  NUM_PROXIES  proxy in matmul mode
proxy_settings  out  NUM_PROXIES*3  per proxy {stat_bit, out_select, op2_select}
proxy_en  out  NUM_PROXIES*ROWS  per-proxy one-hot of assigned row (0 = unassigned)
fault_detected  out  1  captured fault mask is non-zero
uncovered_fault  out  1  more faulty rows than proxies
fault_count  out  $clog2(ROWS)+1  number of faulty rows captured

Behaviour:
- Reset: every output is 0. State goes to IDLE and all internal masks are cleared. Reset has priority in every state, including mid-ALLOC.
- States: IDLE, ALLOC, ARMED, COMPUTE.
- IDLE: outputs are held at 0. On STW_complete=1, the next edge registers fault_mask=~STW_result_mat, remaining=fault_mask, fault_count=popcount and p=0. The block moves to ALLOC if the mask is non-zero and stays in IDLE otherwise. fault_detected follows the registered mask.
- rcm_idx_sel is combinational: the lowest set bit of remaining, or 0 when remaining=0.
- ALLOC, one proxy per cycle. At each edge:
  - rcm_weight[p] <= rcm_in_weight
  - proxy_en[p] <= one-hot(rcm_idx_sel)
  - load_proxy[p] <= 1; strobes from earlier cycles return to 0
  - proxy_settings[p] <= 3'b001
  - clear that bit from remaining; p <= p+1
- Leave ALLOC for ARMED when remaining becomes 0 or p reaches NUM_PROXIES-1. At that point, if remaining is still non-zero, set uncovered_fault=1; it stays sticky until release.
- ALLOC latency: min(fault_count, NUM_PROXIES) cycles after capture.
- ARMED: load_proxy=0 and assignments are held. When matmul_mode=1, the next edge moves to COMPUTE.
- COMPUTE, for each assigned proxy:
  - proxy_matmul=1, proxy_settings=3'b110, rcm_weight=0
  - proxy_left_in[p] <= rcm_left_in slice of its assigned row (1-cycle register delay)
  - Unassigned proxies keep all fields at 0.
- Release: set_stationary_mode=1 in ALLOC, ARMED or COMPUTE clears all assignments, outputs, masks and sticky flags at the next edge and returns to IDLE. This overrides any ALLOC step in the same cycle.
- STW_complete outside IDLE is ignored. If STW_complete and set_stationary_mode are both high in IDLE, capture proceeds.
- Proxies are assigned in ascending row order to proxy 0, 1, ... No row is assigned twice.

Optional Feature:
RCM_FAULT_LOG_EN
- Defined: adds output fault_log [ROWS], a sticky OR of every captured fault_mask. It is cleared only by rst, not by release, and records faults across weight reloads.
- Undefined: port and logic are absent.

Test Plan:
1. STW_result_mat=4'b1111 with STW_complete -> stays IDLE; fault_detected=0; all proxy outputs 0 indefinitely.
2. STW_result_mat=4'b1011 -> rcm_idx_sel=2; rcm_in_weight=16'h00A5 gives rcm_weight[0]=16'h00A5, proxy_en[0]=4'b0100, load_proxy=2'b01 for one cycle, settings[0]=001. Then matmul_mode=1 -> proxy_matmul=2'b01, settings[0]=110, proxy_left_in[0] equals row-2 left input one cycle later.
3. STW_result_mat=4'b0101 -> proxy_en[0]=0010 then proxy_en[1]=1000 on consecutive cycles, load_proxy 01 then 10, fault_count=2, uncovered_fault=0.
4. STW_result_mat=4'b0000 with NUM_PROXIES=2 -> rows 0 and 1 assigned, fault_count=4, uncovered_fault=1.
5. set_stationary_mode=1 during COMPUTE -> next cycle all outputs 0 and state IDLE. A new STW_complete with 4'b1110 reassigns row 0 to proxy 0.
6. rst asserted mid-ALLOC (after proxy 0 is loaded) -> next cycle all outputs 0. STW_complete pulses in ARMED and COMPUTE are ignored. With RCM_FAULT_LOG_EN defined, fault_log survives release but clears on rst.

Source files
------------

// File: rtl/recompute_controller_mp.sv
// recompute_controller_mp: multi-proxy column recompute controller.
// Captures the STW fault map of one systolic column, assigns up to NUM_PROXIES
// spare PEs to faulty rows (lowest row first, one proxy per cycle), loads their
// weights, then routes the faulty rows' left inputs to them during matmul.
// Optional feature macro: RCM_FAULT_LOG_EN adds a sticky fault_log output that
// only rst clears.
module recompute_controller_mp #(
    parameter int ROWS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int NUM_PROXIES = 2,
    parameter int COL_IDX     = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set_stationary_mode,
    input  logic                            matmul_mode,
    input  logic                            STW_complete,
    input  logic [ROWS-1:0]                 STW_result_mat,
    output logic [$clog2(ROWS)-1:0]         rcm_idx_sel,
    input  logic [WORD_SIZE-1:0]            rcm_in_weight,
    input  logic [ROWS*WORD_SIZE-1:0]       rcm_left_in,
    output logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_left_in,
    output logic [NUM_PROXIES*WORD_SIZE-1:0] rcm_weight,
    output logic [NUM_PROXIES-1:0]          load_proxy,
    output logic [NUM_PROXIES-1:0]          proxy_matmul,
    output logic [NUM_PROXIES*3-1:0]        proxy_settings,
    output logic [NUM_PROXIES*ROWS-1:0]     proxy_en,
    output logic                            fault_detected,
`ifdef RCM_FAULT_LOG_EN
    output logic [ROWS-1:0]                 fault_log,
`endif
    output logic                            uncovered_fault,
    output logic [$clog2(ROWS):0]           fault_count
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS) + 1;
    localparam int NP    = NUM_PROXIES;
    localparam int W     = WORD_SIZE;
    localparam int PW    = (NP > 1) ? $clog2(NP) : 1;

    // Reject configurations the allocator cannot serve.
    if (NUM_PROXIES < 1 || NUM_PROXIES > ROWS || COL_IDX < 0) begin : g_param_err
        $error("recompute_controller_mp: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALLOC,
        S_ARMED,
        S_COMPUTE
    } state_e;

    state_e              state_q, state_d;
    logic [ROWS-1:0]     fault_mask_q, fault_mask_d;
    logic [ROWS-1:0]     remaining_q, remaining_d;
    logic [PW-1:0]       p_q, p_d;
    logic [CNT_W-1:0]    fault_count_q, fault_count_d;
    logic                uncovered_q, uncovered_d;
    logic [NP*W-1:0]     weight_q, weight_d;
    logic [NP*W-1:0]     left_q, left_d;
    logic [NP-1:0]       load_q, load_d;
    logic [NP-1:0]       matmul_q, matmul_d;
    logic [NP-1:0]       assigned_q, assigned_d;
    logic [NP*3-1:0]     settings_q, settings_d;
    logic [NP*ROWS-1:0]  en_q, en_d;
`ifdef RCM_FAULT_LOG_EN
    logic [ROWS-1:0]     log_q, log_d;
`endif

    logic [IDX_W-1:0]    idx_sel;
    logic                idx_found;
    logic [ROWS-1:0]     sel_onehot;
    logic [ROWS-1:0]     cap_mask;
    logic [CNT_W-1:0]    cap_count;
    logic [NP*W-1:0]     left_sel;
    logic                release_req;

    // Priority encoder: lowest still-unassigned faulty row drives the weight mux.
    always_comb begin
        idx_sel   = '0;
        idx_found = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!idx_found && remaining_q[r]) begin
                idx_sel   = IDX_W'(r);
                idx_found = 1'b1;
            end
        end
    end

    assign sel_onehot = ROWS'(1) << idx_sel;

    // Fault mask and fault population of the STW result being offered.
    always_comb begin
        cap_mask  = ~STW_result_mat;
        cap_count = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            cap_count = cap_count + CNT_W'(cap_mask[r]);
        end
    end

    // Per-proxy left-input mux selected by the proxy's one-hot row assignment.
    always_comb begin
        left_sel = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (en_q[p*ROWS + r]) begin
                    left_sel[p*W +: W] = rcm_left_in[r*W +: W];
                end
            end
        end
    end

    assign release_req = set_stationary_mode && (state_q != S_IDLE);

    // Next-state and next-output logic for the allocation FSM.
    always_comb begin
        state_d       = state_q;
        fault_mask_d  = fault_mask_q;
        remaining_d   = remaining_q;
        p_d           = p_q;
        fault_count_d = fault_count_q;
        uncovered_d   = uncovered_q;
        weight_d      = weight_q;
        left_d        = left_q;
        load_d        = '0;
        matmul_d      = matmul_q;
        assigned_d    = assigned_q;
        settings_d    = settings_q;
        en_d          = en_q;
`ifdef RCM_FAULT_LOG_EN
        log_d         = log_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (STW_complete) begin
                    fault_mask_d  = cap_mask;
                    remaining_d   = cap_mask;
                    fault_count_d = cap_count;
                    p_d           = '0;
`ifdef RCM_FAULT_LOG_EN
                    log_d         = log_q | cap_mask;
`endif
                    if (|cap_mask) begin
                        state_d = S_ALLOC;
                    end
                end
            end

            S_ALLOC: begin
                weight_d[int'(p_q)*W +: W]        = rcm_in_weight;
                en_d[int'(p_q)*ROWS +: ROWS]      = sel_onehot;
                settings_d[int'(p_q)*3 +: 3]      = 3'b001;
                load_d[p_q]                       = 1'b1;
                assigned_d[p_q]                   = 1'b1;
                remaining_d                       = remaining_q & ~sel_onehot;
                p_d                               = p_q + PW'(1);
                if (remaining_d == '0 || p_q == PW'(NP - 1)) begin
                    state_d     = S_ARMED;
                    uncovered_d = |remaining_d;
                end
            end

            S_ARMED: begin
                if (matmul_mode) begin
                    state_d  = S_COMPUTE;
                    matmul_d = assigned_q;
                    weight_d = '0;
                    for (int unsigned p = 0; p < NP; p++) begin
                        settings_d[p*3 +: 3] = assigned_q[p] ? 3'b110 : 3'b000;
                    end
                end
            end

            S_COMPUTE: begin
                left_d = left_sel;
            end

            default: state_d = S_IDLE;
        endcase

        // Release is evaluated last so it overrides an ALLOC step in the same cycle.
        if (release_req) begin
            state_d       = S_IDLE;
            fault_mask_d  = '0;
            remaining_d   = '0;
            p_d           = '0;
            fault_count_d = '0;
            uncovered_d   = 1'b0;
            weight_d      = '0;
            left_d        = '0;
            load_d        = '0;
            matmul_d      = '0;
            assigned_d    = '0;
            settings_d    = '0;
            en_d          = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fault_mask_q  <= '0;
            remaining_q   <= '0;
            p_q           <= '0;
            fault_count_q <= '0;
            uncovered_q   <= 1'b0;
            weight_q      <= '0;
            left_q        <= '0;
            load_q        <= '0;
            matmul_q      <= '0;
            assigned_q    <= '0;
            settings_q    <= '0;
            en_q          <= '0;
`ifdef RCM_FAULT_LOG_EN
            log_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fault_mask_q  <= fault_mask_d;
            remaining_q   <= remaining_d;
            p_q           <= p_d;
            fault_count_q <= fault_count_d;
            uncovered_q   <= uncovered_d;
            weight_q      <= weight_d;
            left_q        <= left_d;
            load_q        <= load_d;
            matmul_q      <= matmul_d;
            assigned_q    <= assigned_d;
            settings_q    <= settings_d;
            en_q          <= en_d;
`ifdef RCM_FAULT_LOG_EN
            log_q         <= log_d;
`endif
        end
    end

    assign rcm_idx_sel     = idx_sel;
    assign proxy_left_in   = left_q;
    assign rcm_weight      = weight_q;
    assign load_proxy      = load_q;
    assign proxy_matmul    = matmul_q;
    assign proxy_settings  = settings_q;
    assign proxy_en        = en_q;
    assign fault_detected  = |fault_mask_q;
    assign uncovered_fault = uncovered_q;
    assign fault_count     = fault_count_q;
`ifdef RCM_FAULT_LOG_EN
    assign fault_log       = log_q;
`endif

endmodule

// File: tb/tb_recompute_controller_mp.sv
// Self-checking bench for recompute_controller_mp (ROWS=4, WORD_SIZE=16,
// NUM_PROXIES=2). Expected output snapshots are queued as stimulus is driven
// and compared one cycle later, after the active edge.
module tb_recompute_controller_mp;

    localparam int ROWS = 4;
    localparam int W    = 16;
    localparam int NP   = 2;
    localparam int IW   = 2;
    localparam int CW   = 3;

    logic                clk;
    logic                rst;
    logic                set_stationary_mode;
    logic                matmul_mode;
    logic                STW_complete;
    logic [ROWS-1:0]     STW_result_mat;
    logic [IW-1:0]       rcm_idx_sel;
    logic [W-1:0]        rcm_in_weight;
    logic [ROWS*W-1:0]   rcm_left_in;
    logic [NP*W-1:0]     proxy_left_in;
    logic [NP*W-1:0]     rcm_weight;
    logic [NP-1:0]       load_proxy;
    logic [NP-1:0]       proxy_matmul;
    logic [NP*3-1:0]     proxy_settings;
    logic [NP*ROWS-1:0]  proxy_en;
    logic                fault_detected;
    logic                uncovered_fault;
    logic [CW-1:0]       fault_count;
`ifdef RCM_FAULT_LOG_EN
    logic [ROWS-1:0]     fault_log;
`endif

    // External per-row weight store feeding the weight mux.
    logic [W-1:0] wt [ROWS];
    assign rcm_in_weight = wt[rcm_idx_sel];

    recompute_controller_mp #(
        .ROWS(ROWS), .WORD_SIZE(W), .NUM_PROXIES(NP), .COL_IDX(0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .set_stationary_mode (set_stationary_mode),
        .matmul_mode         (matmul_mode),
        .STW_complete        (STW_complete),
        .STW_result_mat      (STW_result_mat),
        .rcm_idx_sel         (rcm_idx_sel),
        .rcm_in_weight       (rcm_in_weight),
        .rcm_left_in         (rcm_left_in),
        .proxy_left_in       (proxy_left_in),
        .rcm_weight          (rcm_weight),
        .load_proxy          (load_proxy),
        .proxy_matmul        (proxy_matmul),
        .proxy_settings      (proxy_settings),
        .proxy_en            (proxy_en),
        .fault_detected      (fault_detected),
`ifdef RCM_FAULT_LOG_EN
        .fault_log           (fault_log),
`endif
        .uncovered_fault     (uncovered_fault),
        .fault_count         (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string              tag;
        logic [IW-1:0]      sel;
        logic [NP*W-1:0]    wt;
        logic [NP-1:0]      ld;
        logic [NP-1:0]      mm;
        logic [NP*3-1:0]    st;
        logic [NP*ROWS-1:0] en;
        logic               fd;
        logic               uf;
        logic [CW-1:0]      cnt;
        logic [NP*W-1:0]    left;
    } snap_t;

    snap_t sb[$];

    function automatic snap_t zs(input string tag);
        snap_t s;
        s.tag = tag; s.sel = '0; s.wt = '0; s.ld = '0; s.mm = '0; s.st = '0;
        s.en = '0; s.fd = 1'b0; s.uf = 1'b0; s.cnt = '0; s.left = '0;
        return s;
    endfunction

    // Queue the expectation, let one edge pass, then compare away from the edge.
    task automatic cyc(input snap_t e);
        snap_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_eq({g.tag, ".sel"},   64'(rcm_idx_sel),     64'(g.sel));
        check_eq({g.tag, ".wt"},    64'(rcm_weight),      64'(g.wt));
        check_eq({g.tag, ".ld"},    64'(load_proxy),      64'(g.ld));
        check_eq({g.tag, ".mm"},    64'(proxy_matmul),    64'(g.mm));
        check_eq({g.tag, ".set"},   64'(proxy_settings),  64'(g.st));
        check_eq({g.tag, ".en"},    64'(proxy_en),        64'(g.en));
        check_eq({g.tag, ".fd"},    64'(fault_detected),  64'(g.fd));
        check_eq({g.tag, ".uf"},    64'(uncovered_fault), 64'(g.uf));
        check_eq({g.tag, ".cnt"},   64'(fault_count),     64'(g.cnt));
        check_eq({g.tag, ".left"},  64'(proxy_left_in),   64'(g.left));
    endtask

    task automatic set_left(input int row, input logic [W-1:0] v);
        rcm_left_in[row*W +: W] = v;
    endtask

    snap_t e;

    initial begin
        wt[0] = 16'h1111; wt[1] = 16'h2222; wt[2] = 16'h00A5; wt[3] = 16'h4444;
        rst = 1'b1; set_stationary_mode = 1'b0; matmul_mode = 1'b0;
        STW_complete = 1'b0; STW_result_mat = '1;
        rcm_left_in = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

        cyc(zs("reset0"));
        cyc(zs("reset1"));
        rst = 1'b0;

        // No faults: stays idle with everything at zero.
        STW_complete = 1'b1; STW_result_mat = 4'b1111;
        cyc(zs("t1_cap"));
        STW_complete = 1'b0;
        cyc(zs("t1_hold0"));
        cyc(zs("t1_hold1"));

        // Single fault on row 2.
        STW_complete = 1'b1; STW_result_mat = 4'b1011;
        e = zs("t2_cap"); e.sel = 2'd2; e.fd = 1'b1; e.cnt = 3'd1;
        cyc(e);
        STW_complete = 1'b0;
        e.tag = "t2_alloc"; e.sel = 2'd0; e.wt = {16'h0000, 16'h00A5}; e.ld = 2'b01;
        e.st = {3'b000, 3'b001}; e.en = {4'b0000, 4'b0100};
        cyc(e);
        e.tag = "t2_armed"; e.ld = 2'b00;
        cyc(e);
        matmul_mode = 1'b1;
        e.tag = "t2_compute"; e.mm = 2'b01; e.st = {3'b000, 3'b110}; e.wt = '0;
        cyc(e);
        set_left(2, 16'hBEEF);
        STW_complete = 1'b1; STW_result_mat = 4'b0000;   // ignored outside IDLE
        e.tag = "t2_left0"; e.left = {16'h0000, 16'hBEEF};
        cyc(e);
        STW_complete = 1'b0;
        set_left(2, 16'hCAFE);
        e.tag = "t2_left1"; e.left = {16'h0000, 16'hCAFE};
        cyc(e);

        // Release from COMPUTE, then capture with set_stationary_mode still high.
        set_stationary_mode = 1'b1; matmul_mode = 1'b0;
        cyc(zs("t5_release"));
        STW_complete = 1'b1; STW_result_mat = 4'b1110;
        e = zs("t5_cap"); e.fd = 1'b1; e.cnt = 3'd1;
        cyc(e);
        STW_complete = 1'b0; set_stationary_mode = 1'b0;
        e.tag = "t5_alloc"; e.wt = {16'h0000, 16'h1111}; e.ld = 2'b01;
        e.st = {3'b000, 3'b001}; e.en = {4'b0000, 4'b0001};
        cyc(e);
        set_stationary_mode = 1'b1;
        cyc(zs("t5_rel_armed"));
        set_stationary_mode = 1'b0;

        // Two faults, both covered, consecutive allocation.
        STW_complete = 1'b1; STW_result_mat = 4'b0101;
        e = zs("t3_cap"); e.sel = 2'd1; e.fd = 1'b1; e.cnt = 3'd2;
        cyc(e);
        STW_complete = 1'b0;
        e.tag = "t3_alloc0"; e.sel = 2'd3; e.wt = {16'h0000, 16'h2222}; e.ld = 2'b01;
        e.st = {3'b000, 3'b001}; e.en = {4'b0000, 4'b0010};
        cyc(e);
        e.tag = "t3_alloc1"; e.sel = 2'd0; e.wt = {16'h4444, 16'h2222}; e.ld = 2'b10;
        e.st = {3'b001, 3'b001}; e.en = {4'b1000, 4'b0010};
        cyc(e);
        STW_complete = 1'b1; STW_result_mat = 4'b1111;   // ignored in ARMED
        e.tag = "t3_armed_ign"; e.ld = 2'b00;
        cyc(e);
        STW_complete = 1'b0; matmul_mode = 1'b1;
        e.tag = "t3_compute"; e.mm = 2'b11; e.st = {3'b110, 3'b110}; e.wt = '0;
        cyc(e);
        set_left(1, 16'h1234); set_left(3, 16'h5678);
        e.tag = "t3_left"; e.left = {16'h5678, 16'h1234};
        cyc(e);
        set_stationary_mode = 1'b1; matmul_mode = 1'b0;
        cyc(zs("t3_release"));
        set_stationary_mode = 1'b0;

        // All rows faulty: more faults than proxies.
        STW_complete = 1'b1; STW_result_mat = 4'b0000;
        e = zs("t4_cap"); e.fd = 1'b1; e.cnt = 3'd4;
        cyc(e);
        STW_complete = 1'b0;
        e.tag = "t4_alloc0"; e.sel = 2'd1; e.wt = {16'h0000, 16'h1111}; e.ld = 2'b01;
        e.st = {3'b000, 3'b001}; e.en = {4'b0000, 4'b0001};
        cyc(e);
        e.tag = "t4_alloc1"; e.sel = 2'd2; e.wt = {16'h2222, 16'h1111}; e.ld = 2'b10;
        e.st = {3'b001, 3'b001}; e.en = {4'b0010, 4'b0001}; e.uf = 1'b1;
        cyc(e);
        e.tag = "t4_armed"; e.ld = 2'b00;
        cyc(e);
        set_stationary_mode = 1'b1;
        cyc(zs("t4_release"));
        set_stationary_mode = 1'b0;
`ifdef RCM_FAULT_LOG_EN
        check_eq("log_after_release", 64'(fault_log), 64'(4'b1111));
`endif

        // Reset mid-ALLOC.
        STW_complete = 1'b1; STW_result_mat = 4'b0011;
        e = zs("t6_cap"); e.sel = 2'd2; e.fd = 1'b1; e.cnt = 3'd2;
        cyc(e);
        STW_complete = 1'b0;
        e.tag = "t6_alloc0"; e.sel = 2'd3; e.wt = {16'h0000, 16'h00A5}; e.ld = 2'b01;
        e.st = {3'b000, 3'b001}; e.en = {4'b0000, 4'b0100};
        cyc(e);
        rst = 1'b1;
        cyc(zs("t6_rst"));
        rst = 1'b0;
`ifdef RCM_FAULT_LOG_EN
        check_eq("log_after_rst", 64'(fault_log), 64'(4'b0000));
`endif

        // Release in the first ALLOC cycle overrides the allocation step.
        STW_complete = 1'b1; STW_result_mat = 4'b1100;
        e = zs("t6_cap2"); e.fd = 1'b1; e.cnt = 3'd2;
        cyc(e);
        STW_complete = 1'b0; set_stationary_mode = 1'b1;
        cyc(zs("t6_rel_alloc"));
        set_stationary_mode = 1'b0;
        cyc(zs("t6_idle"));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
